// File: rtl/issue_scoreboard_pkg.sv
// Shared opcode classes, decoded-instruction bundle and issue FSM states
// for the decode/issue stage.
package issue_pkg;

    localparam int NREGS   = 16;
    localparam int STALL_W = 16;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_STORE = 4'hC;
    localparam logic [3:0] OP_BEQ   = 4'hD;
    localparam logic [3:0] OP_JMP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  reg1;
        logic [3:0]  reg2;
        logic [3:0]  dest;
        logic [15:0] imm;
        logic        uses_src;
        logic        writes_dst;
    } dec_t;

    function automatic logic uses_src(input logic [3:0] op);
        case (op)
            OP_NOP, OP_JMP, OP_HALT: return 1'b0;
            default:                 return 1'b1;
        endcase
    endfunction

    function automatic logic writes_dst(input logic [3:0] op);
        case (op)
            OP_NOP, OP_STORE, OP_BEQ,
            OP_JMP, OP_HALT:         return 1'b0;
            default:                 return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Fetch-in, execute-out, writeback and status signals of the issue stage.
// slave is the issue stage; master is the surrounding pipeline.
interface issue_scoreboard_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [3:0]  out_reg1;
    logic [3:0]  out_reg2;
    logic [3:0]  out_dest;
    logic [15:0] out_imm;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic        flush;
    logic        halted;
    logic [15:0] stall_cycles;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_reg, flush,
        output in_ready, out_valid, out_opcode, out_reg1, out_reg2,
        output out_dest, out_imm, halted, stall_cycles
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_reg, flush,
        input  in_ready, out_valid, out_opcode, out_reg1, out_reg2,
        input  out_dest, out_imm, halted, stall_cycles
    );

endinterface

// File: rtl/issue_scoreboard_decoder.sv
// Splits a fetched instruction word into fields and tags its
// source/destination register usage.
module instruction_decoder
    import issue_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    always_comb begin
        dec            = '0;
        dec.opcode     = instr[31:28];
        dec.reg1       = instr[27:24];
        dec.reg2       = instr[23:20];
        dec.dest       = instr[19:16];
        dec.imm        = instr[15:0];
        dec.uses_src   = uses_src(instr[31:28]);
        dec.writes_dst = writes_dst(instr[31:28]);
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode/issue stage: one-entry hold register, register scoreboard,
// RAW/WAW stall, flush and HALT drain.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    issue_scoreboard_if.slave bus
);

    dec_t                 dec;
    dec_t                 hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [NREGS-1:0]     pending_q, pending_d;
    logic [NREGS-1:0]     pend_eff;
    state_e               state_q, state_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 run;
    logic                 hazard;
    logic                 issue;
    logic                 accept;

    instruction_decoder u_dec (
        .instr (bus.in_instr),
        .dec   (dec)
    );

    always_comb begin
        pend_eff = pending_q;
        if (bus.wb_valid) pend_eff[bus.wb_reg] = 1'b0;
        run    = (state_q == RUN);
        hazard = hold_valid_q &
                 ((hold_q.uses_src &
                   (pend_eff[hold_q.reg1] | pend_eff[hold_q.reg2])) |
                  (hold_q.writes_dst & pend_eff[hold_q.dest]));
        bus.out_valid = rst_n & hold_valid_q & ~hazard & run;
        issue         = bus.out_valid & bus.out_ready;
        bus.in_ready  = rst_n & run & ~bus.flush &
                        (~hold_valid_q | issue);
        accept        = bus.in_valid & bus.in_ready;
    end

    always_comb begin
        bus.out_opcode   = hold_valid_q ? hold_q.opcode : '0;
        bus.out_reg1     = hold_valid_q ? hold_q.reg1   : '0;
        bus.out_reg2     = hold_valid_q ? hold_q.reg2   : '0;
        bus.out_dest     = hold_valid_q ? hold_q.dest   : '0;
        bus.out_imm      = hold_valid_q ? hold_q.imm    : '0;
        bus.halted       = (state_q == HALTED);
        bus.stall_cycles = stall_q;
    end

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_d       = dec;
            hold_valid_d = 1'b1;
        end else if (issue || bus.flush) begin
            hold_valid_d = 1'b0;
        end
        // Set after clear so a same-cycle issue keeps the register busy
        pending_d = pending_q;
        if (bus.wb_valid) pending_d[bus.wb_reg] = 1'b0;
        if (issue && hold_q.writes_dst) pending_d[hold_q.dest] = 1'b1;
        stall_d = stall_q;
        if (hazard && run && stall_q != '1) stall_d = stall_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:
                if (issue && hold_q.opcode == OP_HALT) state_d = DRAIN;
            DRAIN:
                if (pending_d == '0) state_d = HALTED;
            HALTED:
                state_d = HALTED;
            default:
                state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            pending_q    <= '0;
            state_q      <= RUN;
            stall_q      <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus
// random traffic against a cycle-level reference model.
module tb_issue_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    issue_scoreboard_if ifc ();

    issue_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_hv = 1'b0;
    logic [31:0] m_ins = '0;
    bit          m_pend [16];
    int          m_st = 0;
    int          m_stall = 0;

    function automatic bit m_src(input logic [3:0] op);
        return !(op == 4'h0 || op == 4'hE || op == 4'hF);
    endfunction

    function automatic bit m_dst(input logic [3:0] op);
        return !(op == 4'h0 || op >= 4'hC);
    endfunction

    function automatic logic [15:0] m_pvec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [31:0] mk(input int op, input int a,
                                       input int b, input int d,
                                       input int imm);
        logic [31:0] w;
        w = {op[3:0], a[3:0], b[3:0], d[3:0], imm[15:0]};
        return w;
    endfunction

    task automatic idle();
        ifc.in_valid  = 1'b0;
        ifc.in_instr  = '0;
        ifc.out_ready = 1'b1;
        ifc.wb_valid  = 1'b0;
        ifc.wb_reg    = '0;
        ifc.flush     = 1'b0;
    endtask

    // One clock: check DUT outputs against model, then advance model
    task automatic cycle(input bit chk);
        bit pe [16];
        bit haz, ov, ir, iss, acc, any;
        logic [3:0] op, r1, r2, d;
        logic [31:0] exp_f, got_f;
        #2;
        pe = m_pend;
        if (ifc.wb_valid) pe[ifc.wb_reg] = 1'b0;
        op = m_ins[31:28];
        r1 = m_ins[27:24];
        r2 = m_ins[23:20];
        d  = m_ins[19:16];
        haz = m_hv && ((m_src(op) && (pe[r1] || pe[r2])) ||
                       (m_dst(op) && pe[d]));
        ov  = rst_n && m_hv && !haz && m_st == 0;
        iss = ov && ifc.out_ready;
        ir  = rst_n && m_st == 0 && !ifc.flush && (!m_hv || iss);
        acc = ifc.in_valid && ir;
        if (chk) begin
            exp_f = m_hv ? m_ins : 32'h0;
            got_f = {ifc.out_opcode, ifc.out_reg1, ifc.out_reg2,
                     ifc.out_dest, ifc.out_imm};
            checks += 6;
            if (ifc.out_valid !== ov) begin
                failures++;
                $display("FAIL out_valid t=%0t got %b exp %b",
                         $time, ifc.out_valid, ov);
            end
            if (ifc.in_ready !== ir) begin
                failures++;
                $display("FAIL in_ready t=%0t got %b exp %b",
                         $time, ifc.in_ready, ir);
            end
            if (got_f !== exp_f) begin
                failures++;
                $display("FAIL out_fields t=%0t got %h exp %h",
                         $time, got_f, exp_f);
            end
            if (ifc.halted !== (m_st == 2)) begin
                failures++;
                $display("FAIL halted t=%0t got %b exp %b",
                         $time, ifc.halted, m_st == 2);
            end
            if (ifc.stall_cycles !== 16'(m_stall)) begin
                failures++;
                $display("FAIL stall_cycles t=%0t got %0d exp %0d",
                         $time, ifc.stall_cycles, m_stall);
            end
            if (dut.pending_q !== m_pvec()) begin
                failures++;
                $display("FAIL pending t=%0t got %h exp %h",
                         $time, dut.pending_q, m_pvec());
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_hv = 0;
            m_st = 0;
            m_stall = 0;
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
        end else begin
            if (haz && m_st == 0 && m_stall < 65535) m_stall++;
            if (ifc.wb_valid) m_pend[ifc.wb_reg] = 0;
            if (iss && m_dst(op)) m_pend[d] = 1;
            any = 0;
            for (int i = 0; i < 16; i++) any |= m_pend[i];
            if (m_st == 0 && iss && op == 4'hF) m_st = 1;
            else if (m_st == 1 && !any) m_st = 2;
            if (acc) begin
                m_hv  = 1;
                m_ins = ifc.in_instr;
            end else if (iss || ifc.flush) begin
                m_hv = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cycle(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready got %b exp 0", ifc.in_ready);
        end
        if (ifc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got %b exp 0", ifc.out_valid);
        end
        cycle(1);
        rst_n = 1'b1;
        #1;
        checks += 4;
        if (ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_in_ready got %b exp 1", ifc.in_ready);
        end
        if (ifc.halted !== 1'b0 || ifc.stall_cycles !== 16'h0) begin
            failures++;
            $display("FAIL post_rst_status got %b/%0d exp 0/0",
                     ifc.halted, ifc.stall_cycles);
        end
        if (dut.pending_q !== 16'h0) begin
            failures++;
            $display("FAIL post_rst_pending got %h exp 0", dut.pending_q);
        end
        if ({ifc.out_opcode, ifc.out_dest, ifc.out_imm} !== 24'h0) begin
            failures++;
            $display("FAIL post_rst_fields got %h exp 0",
                     {ifc.out_opcode, ifc.out_dest, ifc.out_imm});
        end
        cycle(1);
    endtask

    task automatic test_stream();
        do_reset();
        ifc.in_valid = 1'b1;
        ifc.in_instr = mk(1, 1, 2, 3, 16'h0011);
        cycle(1);
        ifc.in_instr = mk(1, 4, 5, 6, 16'h0022);
        #1;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_dest !== 4'd3) begin
            failures++;
            $display("FAIL stream_first got v=%b d=%0d exp v=1 d=3",
                     ifc.out_valid, ifc.out_dest);
        end
        cycle(1);
        ifc.in_valid = 1'b0;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_dest !== 4'd6) begin
            failures++;
            $display("FAIL stream_second got v=%b d=%0d exp v=1 d=6",
                     ifc.out_valid, ifc.out_dest);
        end
        cycle(1);
        cycle(1);
        checks += 2;
        if (dut.pending_q !== 16'h0048) begin
            failures++;
            $display("FAIL stream_pending got %h exp 0048", dut.pending_q);
        end
        if (ifc.stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL stream_stall got %0d exp 0", ifc.stall_cycles);
        end
    endtask

    task automatic test_raw();
        do_reset();
        ifc.in_valid = 1'b1;
        ifc.in_instr = mk(1, 1, 2, 3, 0);
        cycle(1);
        ifc.in_instr = mk(2, 3, 1, 7, 0);
        cycle(1);
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ifc.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL raw_stall[%0d] got %b exp 0",
                         i, ifc.out_valid);
            end
            cycle(1);
        end
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 4'd3;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_dest !== 4'd7) begin
            failures++;
            $display("FAIL raw_release got v=%b d=%0d exp v=1 d=7",
                     ifc.out_valid, ifc.out_dest);
        end
        cycle(1);
        idle();
        checks++;
        if (ifc.stall_cycles !== 16'd4) begin
            failures++;
            $display("FAIL raw_stall_count got %0d exp 4",
                     ifc.stall_cycles);
        end
        cycle(1);
    endtask

    task automatic test_waw();
        do_reset();
        ifc.in_valid = 1'b1;
        ifc.in_instr = mk(1, 8, 9, 3, 0);
        cycle(1);
        ifc.in_instr = mk(1, 1, 2, 3, 0);
        cycle(1);
        ifc.in_valid = 1'b0;
        cycle(1);
        cycle(1);
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 4'd3;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL waw_release got %b exp 1", ifc.out_valid);
        end
        cycle(1);
        idle();
        checks++;
        if (dut.pending_q[3] !== 1'b1) begin
            failures++;
            $display("FAIL waw_set_wins got %b exp 1", dut.pending_q[3]);
        end
        cycle(1);
    endtask

    task automatic test_hold_flush();
        do_reset();
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_instr  = mk(1, 1, 2, 5, 16'h1234);
        cycle(1);
        ifc.in_instr = mk(3, 6, 7, 8, 16'h5678);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks += 2;
            if ({ifc.out_opcode, ifc.out_reg1, ifc.out_reg2,
                 ifc.out_dest, ifc.out_imm} !== 32'h1125_1234) begin
                failures++;
                $display("FAIL hold_fields[%0d] got %h exp 11251234", i,
                         {ifc.out_opcode, ifc.out_reg1, ifc.out_reg2,
                          ifc.out_dest, ifc.out_imm});
            end
            if (ifc.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_in_ready[%0d] got %b exp 0",
                         i, ifc.in_ready);
            end
            cycle(1);
        end
        ifc.in_valid = 1'b0;
        ifc.flush    = 1'b1;
        cycle(1);
        ifc.flush = 1'b0;
        #1;
        checks += 2;
        if (ifc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_out_valid got %b exp 0", ifc.out_valid);
        end
        if (dut.pending_q !== 16'h0) begin
            failures++;
            $display("FAIL flush_pending got %h exp 0", dut.pending_q);
        end
        cycle(1);
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        ifc.in_valid = 1'b1;
        ifc.in_instr = mk(1, 1, 1, 2, 0);
        cycle(1);
        ifc.in_instr = mk(15, 0, 0, 0, 0);
        cycle(1);
        ifc.in_instr = mk(1, 4, 4, 4, 0);
        cycle(1);
        ifc.flush = 1'b1;
        #1;
        checks += 2;
        if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_in_ready got %b exp 0", ifc.in_ready);
        end
        if (ifc.halted !== 1'b0) begin
            failures++;
            $display("FAIL drain_halted got %b exp 0", ifc.halted);
        end
        cycle(1);
        ifc.flush    = 1'b0;
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 4'd2;
        cycle(1);
        ifc.wb_valid = 1'b0;
        checks++;
        if (ifc.halted !== 1'b1) begin
            failures++;
            $display("FAIL halted_after_wb got %b exp 1", ifc.halted);
        end
        cycle(1);
        cycle(1);
        idle();
    endtask

    task automatic test_reset_mid_and_saturate();
        do_reset();
        ifc.in_valid = 1'b1;
        ifc.in_instr = mk(1, 1, 1, 2, 0);
        cycle(1);
        ifc.in_instr = mk(2, 2, 1, 9, 0);
        cycle(1);
        ifc.in_valid = 1'b0;
        cycle(1);
        rst_n = 1'b0;
        cycle(1);
        rst_n = 1'b1;
        checks += 3;
        if (ifc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_out_valid got %b exp 0", ifc.out_valid);
        end
        if (dut.pending_q !== 16'h0) begin
            failures++;
            $display("FAIL midrst_pending got %h exp 0", dut.pending_q);
        end
        if (ifc.stall_cycles !== 16'h0) begin
            failures++;
            $display("FAIL midrst_stall got %0d exp 0", ifc.stall_cycles);
        end
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 4'd2;
        cycle(1);
        idle();
        ifc.in_valid = 1'b1;
        ifc.in_instr = mk(1, 1, 1, 3, 0);
        cycle(1);
        ifc.in_instr = mk(2, 3, 3, 4, 0);
        cycle(1);
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 70000; i++) cycle(0);
        cycle(1);
        checks++;
        if (ifc.stall_cycles !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_saturate got %h exp FFFF",
                     ifc.stall_cycles);
        end
    endtask

    task automatic test_random();
        int op;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 14);
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            ifc.in_instr  = mk(op, $urandom_range(0, 3),
                               $urandom_range(0, 3),
                               $urandom_range(0, 3), $urandom);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            ifc.wb_valid  = ($urandom_range(0, 2) == 0);
            ifc.wb_reg    = 4'($urandom_range(0, 3));
            ifc.flush     = ($urandom_range(0, 9) == 0);
            cycle(1);
        end
        idle();
        cycle(1);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cycle(0);
        test_reset();
        test_stream();
        test_raw();
        test_waw();
        test_hold_flush();
        test_halt();
        test_random();
        test_reset_mid_and_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
